// File: rtl/alu_issuer.sv
// Command issuer for an external combinational ALU.
// Registers operands, captures the ALU result into an accumulator and hands it to a consumer.
//
// state | meaning
// IDLE  | ready for a command; A/B/ALUOp hold their last values
// ISSUE | registered operands presented to the ALU for one cycle
// RESP  | result (or error) presented until the consumer takes it
module alu_issuer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_use_acc,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  output logic [31:0]      A,
  output logic [31:0]      B,
  output logic [2:0]       ALUOp,
  input  logic [31:0]      C,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_err,
  output logic [31:0]      acc,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state_q, state_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      res_data_q, res_data_d;
  logic             res_err_q, res_err_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic op_supported;
  logic op_is_shift;

  assign op_supported = (cmd_op <= 3'd5);
  assign op_is_shift  = (cmd_op == 3'd4) || (cmd_op == 3'd5);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          a_d  = cmd_use_acc ? acc_q : cmd_a;
          // shifts only honour a 5-bit amount
          b_d  = op_is_shift ? {27'b0, cmd_b[4:0]} : cmd_b;
          op_d = cmd_op;
          if (op_supported) begin
            state_d = ISSUE;
          end else begin
            res_data_d = 32'b0;
            res_err_d  = 1'b1;
            state_d    = RESP;
          end
        end
      end
      ISSUE: begin
        res_data_d = C;
        acc_d      = C;
        res_err_d  = 1'b0;
        cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d    = RESP;
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= 32'b0;
      b_q        <= 32'b0;
      op_q       <= 3'b000;
      res_data_q <= 32'b0;
      res_err_q  <= 1'b0;
      acc_q      <= 32'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == RESP);
  assign A         = a_q;
  assign B         = b_q;
  assign ALUOp     = op_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign acc       = acc_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer with a reference ALU closing the A/B/ALUOp -> C loop.
module tb_alu_issuer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'd0;
  logic             cmd_use_acc = 1'b0;
  logic [31:0]      cmd_a = 32'd0;
  logic [31:0]      cmd_b = 32'd0;
  logic [31:0]      A, B, C;
  logic [2:0]       ALUOp;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [31:0]      res_data;
  logic             res_err;
  logic [31:0]      acc;
  logic [CNT_W-1:0] op_count;

  int n_chk  = 0;
  int n_pass = 0;
  int lat;

  alu_issuer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_use_acc(cmd_use_acc), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .A(A), .B(B), .ALUOp(ALUOp), .C(C),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .acc(acc), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // reference ALU
  always_comb begin
    C = 32'd0;
    case (ALUOp)
      3'd0: C = A + B;
      3'd1: C = A - B;
      3'd2: C = A & B;
      3'd3: C = A | B;
      3'd4: C = A >> B[4:0];
      3'd5: C = 32'($signed(A) >>> B[4:0]);
      default: C = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one command; lat = edges from acceptance edge (inclusive) to res_valid.
  task automatic issue(input logic [2:0] op, input logic use_acc,
                       input logic [31:0] a, input logic [31:0] b, output int l);
    cmd_op = op; cmd_use_acc = use_acc; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    l = 1;
    while (!res_valid && l < 10) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic release_resp();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_acc", acc, 32'd0);
    chk("rst_A", A, 32'd0);
    chk("rst_ALUOp", 32'(ALUOp), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // add 5+7
    issue(3'd0, 1'b0, 32'd5, 32'd7, lat);
    chk("add_lat", 32'(lat), 32'd2);
    chk("add_data", res_data, 32'd12);
    chk("add_acc", acc, 32'd12);
    chk("add_cnt", 32'(op_count), 32'd1);
    chk("add_err", 32'(res_err), 32'd0);
    release_resp();
    chk("add_idle", 32'(cmd_ready), 32'd1);

    // sub acc-20, checking operands during ISSUE
    cmd_op = 3'd1; cmd_use_acc = 1'b1; cmd_a = 32'hDEAD_BEEF; cmd_b = 32'd20; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("sub_issue_A", A, 32'd12);
    chk("sub_issue_B", B, 32'd20);
    chk("sub_issue_op", 32'(ALUOp), 32'd1);
    chk("sub_issue_rdy", 32'(cmd_ready), 32'd0);
    chk("sub_issue_vld", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    chk("sub_vld", 32'(res_valid), 32'd1);
    chk("sub_data", res_data, 32'hFFFF_FFF8);
    chk("sub_acc", acc, 32'hFFFF_FFF8);
    chk("sub_cnt", 32'(op_count), 32'd2);
    chk("sub_A_hold", A, 32'd12);
    release_resp();

    // sra with oversized shift amount
    cmd_op = 3'd5; cmd_use_acc = 1'b0; cmd_a = 32'h8000_0000; cmd_b = 32'h0000_0024; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("sra_B", B, 32'd4);
    @(posedge clk); #1;
    chk("sra_data", res_data, 32'hF800_0000);
    chk("sra_cnt", 32'(op_count), 32'd3);
    release_resp();

    // srl masks B too
    issue(3'd4, 1'b0, 32'h8000_0000, 32'hFFFF_FFE4, lat);
    chk("srl_B", B, 32'd4);
    chk("srl_data", res_data, 32'h0800_0000);
    release_resp();

    // or, then set acc to 12
    issue(3'd3, 1'b0, 32'h0000_00F0, 32'h0000_0F0F, lat);
    chk("or_data", res_data, 32'h0000_0FFF);
    release_resp();
    issue(3'd0, 1'b0, 32'd12, 32'd0, lat);
    chk("acc12", acc, 32'd12);
    chk("acc12_cnt", 32'(op_count), 32'd6);
    release_resp();

    // unsupported opcode
    issue(3'd6, 1'b0, 32'd3, 32'd4, lat);
    chk("bad_lat", 32'(lat), 32'd1);
    chk("bad_err", 32'(res_err), 32'd1);
    chk("bad_data", res_data, 32'd0);
    chk("bad_acc", acc, 32'd12);
    chk("bad_cnt", 32'(op_count), 32'd6);
    release_resp();

    // and with a stalled consumer
    issue(3'd2, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, lat);
    chk("and_err", 32'(res_err), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_vld", 32'(res_valid), 32'd1);
      chk("stall_data", res_data, 32'h0000_F000);
      chk("stall_rdy", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
    end
    release_resp();
    chk("stall_rel_vld", 32'(res_valid), 32'd0);
    chk("stall_rel_rdy", 32'(cmd_ready), 32'd1);
    chk("and_cnt", 32'(op_count), 32'd7);

    // counter wraps at CNT_W bits: 9 more ops -> 16 -> 0
    for (int i = 0; i < 9; i++) begin
      issue(3'd0, 1'b0, 32'(i), 32'd1, lat);
      release_resp();
    end
    chk("cnt_wrap", 32'(op_count), 32'd0);
    chk("wrap_acc", acc, 32'd9);

    // reset during ISSUE of 1+1 with acc=9
    cmd_op = 3'd0; cmd_use_acc = 1'b0; cmd_a = 32'd1; cmd_b = 32'd1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("rst2_in_issue", 32'(cmd_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst2_acc", acc, 32'd0);
    chk("rst2_vld", 32'(res_valid), 32'd0);
    chk("rst2_rdy", 32'(cmd_ready), 32'd1);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst2_no_res", 32'(res_valid), 32'd0);
    chk("rst2_acc_after", acc, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 Parameter CNT_W, default 16, width of the completed-operation counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request present.
REQ-005 cmd_ready  output  1  issuer can accept a command this cycle.
REQ-006 cmd_op  input  3  ALU operation code: 000 add, 001 sub, 010 and, 011 or, 100 logical shift right, 101 arithmetic shift right.
REQ-007 cmd_use_acc  input  1  when 1, operand A is the accumulator and cmd_a is ignored.
REQ-008 cmd_a  input  32  operand A.
REQ-009 cmd_b  input  32  operand B.
REQ-010 A  output  32  operand A driven to the external combinational ALU.
REQ-011 B  output  32  operand B driven to the external ALU.
REQ-012 ALUOp  output  3  operation code driven to the external ALU.
REQ-013 C  input  32  combinational result returned by the external ALU.
REQ-014 res_valid  output  1  result available.
REQ-015 res_ready  input  1  consumer accepts the result.
REQ-016 res_data  output  32  captured result.
REQ-017 res_err  output  1  result belongs to an unsupported opcode.
REQ-018 acc  output  32  accumulator, last successful result.
REQ-019 op_count  output  CNT_W  number of successful operations completed.

Function
REQ-020 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-021 In IDLE, cmd_ready SHALL be 1. In ISSUE and RESP, cmd_ready SHALL be 0.
REQ-022 In IDLE with cmd_valid=1, the issuer SHALL latch the command into A, B and ALUOp. A SHALL take acc if cmd_use_acc=1, else cmd_a.
REQ-023 On acceptance of a supported opcode (000-101), the next state SHALL be ISSUE.
REQ-024 For opcodes 100 and 101, the latched B SHALL be {27'b0, cmd_b[4:0]}. For all other opcodes, B SHALL be cmd_b unmodified.
REQ-025 On acceptance of an unsupported opcode (110, 111), the issuer SHALL:
  - go directly to RESP;
  - set res_err=1 and res_data=0;
  - leave acc and op_count unchanged;
  - not enter ISSUE.
REQ-026 A, B and ALUOp SHALL be registered and stable for the whole ISSUE cycle.
REQ-027 At the end of the ISSUE cycle, the issuer SHALL:
  - capture C into res_data and into acc;
  - set res_err=0;
  - increment op_count by 1, wrapping from all-ones to 0;
  - go to RESP.
REQ-028 In RESP, res_valid SHALL be 1. res_data, res_err and acc SHALL hold until res_valid and res_ready are both 1; the next state SHALL then be IDLE.
REQ-029 res_ready SHALL be ignored outside RESP, and res_valid SHALL be 0 outside RESP.
REQ-030 Latency from command acceptance to res_valid SHALL be 2 cycles for supported opcodes and 1 cycle for unsupported opcodes.
REQ-031 Maximum throughput SHALL be one command per 3 cycles.
REQ-032 A, B and ALUOp SHALL retain their last values in IDLE and RESP.
REQ-033 All arithmetic SHALL be performed by the external ALU; the issuer SHALL add no internal arithmetic other than the op_count increment.

Reset
REQ-034 While reset=1, the issuer SHALL immediately (asynchronously) force:
  - state to IDLE;
  - A, B, res_data, acc and op_count to 0;
  - ALUOp to 000;
  - res_valid and res_err to 0.
REQ-035 A reset asserted in ISSUE or RESP SHALL discard the pending result without updating acc.

Verification
REQ-036 The bench SHALL connect a reference combinational ALU model to A, B, ALUOp and C.
REQ-037 Scenario: after reset, cmd add, a=5, b=7, use_acc=0 -> res_valid 2 cycles after acceptance, res_data=12, acc=12, op_count=1.
REQ-038 Scenario: then cmd sub, use_acc=1, b=20 -> res_data=0xFFFFFFF8, acc=0xFFFFFFF8, op_count=2.
REQ-039 Scenario: cmd sra, a=0x80000000, b=0x00000024 -> latched B=4, res_data=0xF8000000.
REQ-040 Scenario: cmd op 110 with acc=12 -> res_valid 1 cycle after acceptance, res_err=1, res_data=0, acc stays 12, op_count unchanged.
REQ-041 Scenario: res_ready held 0 for 5 cycles in RESP -> res_valid and res_data stable, cmd_ready=0 throughout; release -> IDLE on the next cycle.
REQ-042 Scenario: reset asserted during ISSUE of add 1+1 with acc=9 -> acc=0, res_valid=0 immediately; no result delivered.
